// File: rtl/guvm_cache_responder.sv
// Cache responder for a core bench: instruction-queue fetch path with stall/NOP
// injection, and a wait-stated data port that serves loads from a load-data queue.
module guvm_cache_responder #(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        IQ_DEPTH = 8,
  parameter int unsigned        LQ_DEPTH = 4,
  parameter int unsigned        WAIT_W   = 4,
  parameter logic [DATA_W-1:0]  NOP_WORD = 32'h01000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iq_push_valid,
  input  logic [DATA_W-1:0] iq_push_data,
  output logic              iq_push_ready,
  input  logic              lq_push_valid,
  input  logic [DATA_W-1:0] lq_push_data,
  output logic              lq_push_ready,
  input  logic              nop_mode,
  input  logic [WAIT_W-1:0] wait_cycles,
  input  logic              fetch_req,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_stall,
  input  logic              dc_req,
  input  logic              dc_write,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_stall,
  output logic              dc_done,
  output logic              st_valid,
  output logic [DATA_W-1:0] st_data,
  output logic              ld_underflow,
  output logic [15:0]       fetch_count
);

  localparam int unsigned IAW = $clog2(IQ_DEPTH);
  localparam int unsigned LAW = $clog2(LQ_DEPTH);
  localparam int unsigned ICW = IAW + 1;
  localparam int unsigned LCW = LAW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  // Instruction queue
  logic [DATA_W-1:0] iq_mem_q [IQ_DEPTH];
  logic [IAW-1:0]    iq_rd_q, iq_wr_q;
  logic [ICW-1:0]    iq_cnt_q;
  logic              iq_full, iq_empty, iq_push, iq_pop;
  logic [DATA_W-1:0] iq_head;

  // Load-data queue
  logic [DATA_W-1:0] lq_mem_q [LQ_DEPTH];
  logic [LAW-1:0]    lq_rd_q, lq_wr_q;
  logic [LCW-1:0]    lq_cnt_q;
  logic              lq_full, lq_empty, lq_push, lq_pop;
  logic [DATA_W-1:0] lq_head;

  // Fetch path
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;
  logic [15:0]       fcnt_q, fcnt_d;

  // Data path
  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] sthold_q, sthold_d;
  logic              under_q, under_d;

  assign iq_full  = (iq_cnt_q == ICW'(IQ_DEPTH));
  assign iq_empty = (iq_cnt_q == '0);
  assign iq_head  = iq_mem_q[iq_rd_q];
  assign iq_push  = iq_push_valid && !iq_full;
  assign lq_full  = (lq_cnt_q == LCW'(LQ_DEPTH));
  assign lq_empty = (lq_cnt_q == '0);
  assign lq_head  = lq_mem_q[lq_rd_q];
  assign lq_push  = lq_push_valid && !lq_full;

  assign iq_push_ready = !iq_full;
  assign lq_push_ready = !lq_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iq_rd_q  <= '0;
      iq_wr_q  <= '0;
      iq_cnt_q <= '0;
      lq_rd_q  <= '0;
      lq_wr_q  <= '0;
      lq_cnt_q <= '0;
    end else begin
      if (iq_push) iq_wr_q <= iq_wr_q + 1'b1;
      if (iq_pop)  iq_rd_q <= iq_rd_q + 1'b1;
      iq_cnt_q <= iq_cnt_q + ICW'(iq_push) - ICW'(iq_pop);
      if (lq_push) lq_wr_q <= lq_wr_q + 1'b1;
      if (lq_pop)  lq_rd_q <= lq_rd_q + 1'b1;
      lq_cnt_q <= lq_cnt_q + LCW'(lq_push) - LCW'(lq_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (iq_push) iq_mem_q[iq_wr_q] <= iq_push_data;
    if (lq_push) lq_mem_q[lq_wr_q] <= lq_push_data;
  end

  // A pending fetch only resolves with a real word, never with a NOP.
  always_comb begin
    pend_d  = pend_q;
    fdata_d = fdata_q;
    fcnt_d  = fcnt_q;
    iq_pop  = 1'b0;
    if (pend_q || fetch_req) begin
      if (!iq_empty) begin
        iq_pop  = 1'b1;
        fdata_d = iq_head;
        pend_d  = 1'b0;
        fcnt_d  = fcnt_q + 1'b1;
      end else if (!pend_q && nop_mode) begin
        fdata_d = NOP_WORD;
        fcnt_d  = fcnt_q + 1'b1;
      end else begin
        pend_d  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    sthold_d = sthold_q;
    under_d  = under_q;
    lq_pop   = 1'b0;
    dc_stall = 1'b0;
    dc_done  = 1'b0;
    st_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dc_req) begin
          wr_d    = dc_write;
          wdata_d = dc_wdata;
          cnt_d   = wait_cycles;
          state_d = (wait_cycles != '0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        dc_stall = 1'b1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == WAIT_W'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        dc_done = 1'b1;
        state_d = S_IDLE;
        if (wr_q) begin
          st_valid = 1'b1;
          sthold_d = wdata_q;
        end else if (lq_empty) begin
          rdata_d = '0;
          under_d = 1'b1;
        end else begin
          lq_pop  = 1'b1;
          rdata_d = lq_head;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next-state values double as the visible outputs so RESP shows its result
  // in the same cycle while the registers hold it afterwards.
  assign dc_rdata     = rdata_d;
  assign st_data      = sthold_d;
  assign ld_underflow = under_d;
  assign fetch_data   = fdata_q;
  assign fetch_stall  = pend_q;
  assign fetch_count  = fcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q   <= 1'b0;
      fdata_q  <= NOP_WORD;
      fcnt_q   <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      sthold_q <= '0;
      under_q  <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      fdata_q  <= fdata_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      sthold_q <= sthold_d;
      under_q  <= under_d;
    end
  end

endmodule

// File: tb/tb_guvm_cache_responder.sv
// Bench for guvm_cache_responder: queue/countdown reference model checked every
// cycle, plus directed literal scenarios and randomized traffic with reset pulses.
module tb_guvm_cache_responder;
  localparam int unsigned DW  = 32;
  localparam int unsigned IQD = 8;
  localparam int unsigned LQD = 4;
  localparam int unsigned WW  = 4;
  localparam logic [31:0] NOP = 32'h01000000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iq_push_valid, lq_push_valid, nop_mode, fetch_req, dc_req, dc_write;
  logic [DW-1:0] iq_push_data, lq_push_data, dc_wdata;
  logic [WW-1:0] wait_cycles;
  logic          iq_push_ready, lq_push_ready, fetch_stall, dc_stall, dc_done, st_valid, ld_underflow;
  logic [DW-1:0] fetch_data, dc_rdata, st_data;
  logic [15:0]   fetch_count;

  guvm_cache_responder #(
    .DATA_W(DW), .IQ_DEPTH(IQD), .LQ_DEPTH(LQD), .WAIT_W(WW), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .rst(rst),
    .iq_push_valid(iq_push_valid), .iq_push_data(iq_push_data), .iq_push_ready(iq_push_ready),
    .lq_push_valid(lq_push_valid), .lq_push_data(lq_push_data), .lq_push_ready(lq_push_ready),
    .nop_mode(nop_mode), .wait_cycles(wait_cycles),
    .fetch_req(fetch_req), .fetch_data(fetch_data), .fetch_stall(fetch_stall),
    .dc_req(dc_req), .dc_write(dc_write), .dc_wdata(dc_wdata), .dc_rdata(dc_rdata),
    .dc_stall(dc_stall), .dc_done(dc_done), .st_valid(st_valid), .st_data(st_data),
    .ld_underflow(ld_underflow), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queues of words, a pending flag, and a countdown to completion.
  logic [31:0] m_iq[$];
  logic [31:0] m_lq[$];
  bit          m_pend, m_act, m_wr, m_under;
  int          m_left;
  int unsigned m_fcnt;
  logic [31:0] m_fdata, m_wdata, m_rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_iq.delete();
      m_lq.delete();
      m_pend  = 1'b0;
      m_fdata = NOP;
      m_fcnt  = 0;
      m_act   = 1'b0;
      m_left  = 0;
      m_wr    = 1'b0;
      m_wdata = '0;
      m_rdata = '0;
      m_under = 1'b0;
    end else begin : model_step
      bit iq_ne, lq_ne, iq_ok, lq_ok;
      iq_ne = (m_iq.size() != 0);
      lq_ne = (m_lq.size() != 0);
      iq_ok = iq_push_valid && (m_iq.size() < IQD);
      lq_ok = lq_push_valid && (m_lq.size() < LQD);
      if (m_pend || fetch_req) begin
        if (iq_ne) begin
          m_fdata = m_iq.pop_front();
          m_pend  = 1'b0;
          m_fcnt  = (m_fcnt + 1) % 65536;
        end else if (!m_pend && nop_mode) begin
          m_fdata = NOP;
          m_fcnt  = (m_fcnt + 1) % 65536;
        end else begin
          m_pend = 1'b1;
        end
      end
      if (m_act) begin
        if (m_left == 0) begin
          m_act = 1'b0;
          if (!m_wr) begin
            if (lq_ne) m_rdata = m_lq.pop_front();
            else begin
              m_rdata = '0;
              m_under = 1'b1;
            end
          end
        end else begin
          m_left--;
        end
      end else if (dc_req) begin
        m_act   = 1'b1;
        m_left  = int'(wait_cycles);
        m_wr    = dc_write;
        m_wdata = dc_wdata;
      end
      if (iq_ok) m_iq.push_back(iq_push_data);
      if (lq_ok) m_lq.push_back(lq_push_data);
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin : compare
      bit          done, ld_done;
      logic [31:0] exp_rd;
      done    = m_act && (m_left == 0);
      ld_done = done && !m_wr;
      exp_rd  = m_rdata;
      if (ld_done) exp_rd = (m_lq.size() != 0) ? m_lq[0] : 32'h0;
      chk("iq_push_ready", iq_push_ready, m_iq.size() < IQD);
      chk("lq_push_ready", lq_push_ready, m_lq.size() < LQD);
      chk("fetch_data", fetch_data, m_fdata);
      chk("fetch_stall", fetch_stall, m_pend);
      chk("fetch_count", fetch_count, m_fcnt);
      chk("dc_stall", dc_stall, m_act && (m_left > 0));
      chk("dc_done", dc_done, done);
      chk("st_valid", st_valid, done && m_wr);
      if (done && m_wr) chk("st_data", st_data, m_wdata);
      chk("dc_rdata", dc_rdata, exp_rd);
      chk("ld_underflow", ld_underflow, m_under || (ld_done && m_lq.size() == 0));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_in();
    iq_push_valid = 1'b0;
    lq_push_valid = 1'b0;
    fetch_req     = 1'b0;
    dc_req        = 1'b0;
    dc_write      = 1'b0;
    iq_push_data  = '0;
    lq_push_data  = '0;
    dc_wdata      = '0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_fetch_data"}, fetch_data, NOP);
    chk({tag, "_fetch_stall"}, fetch_stall, 1'b0);
    chk({tag, "_dc_rdata"}, dc_rdata, 32'h0);
    chk({tag, "_dc_stall"}, dc_stall, 1'b0);
    chk({tag, "_dc_done"}, dc_done, 1'b0);
    chk({tag, "_st_valid"}, st_valid, 1'b0);
    chk({tag, "_st_data"}, st_data, 32'h0);
    chk({tag, "_ld_underflow"}, ld_underflow, 1'b0);
    chk({tag, "_fetch_count"}, fetch_count, 16'h0);
    chk({tag, "_iq_ready"}, iq_push_ready, 1'b1);
    chk({tag, "_lq_ready"}, lq_push_ready, 1'b1);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    idle_in();
    nop_mode    = 1'b0;
    wait_cycles = '0;
    cyc();
    cyc();
    do_reset("rst0");
    chk_en = 1'b1;

    // Two pushed words fetched back to back
    iq_push_valid = 1'b1; iq_push_data = 32'h8E00C002; cyc();
    iq_push_data = 32'h01000000; cyc();
    iq_push_valid = 1'b0; fetch_req = 1'b1; cyc();
    chk("f1_data", fetch_data, 32'h8E00C002);
    chk("f1_stall", fetch_stall, 1'b0);
    cyc();
    fetch_req = 1'b0;
    chk("f2_data", fetch_data, 32'h01000000);
    chk("f2_count", fetch_count, 16'd2);

    // Stall on empty queue until a word arrives three cycles later
    fetch_req = 1'b1; cyc();
    fetch_req = 1'b0;
    chk("st_stall0", fetch_stall, 1'b1);
    cyc(); chk("st_stall1", fetch_stall, 1'b1);
    cyc(); chk("st_stall2", fetch_stall, 1'b1);
    iq_push_valid = 1'b1; iq_push_data = 32'hA0002001; cyc();
    iq_push_valid = 1'b0;
    chk("st_stall3", fetch_stall, 1'b1);
    cyc();
    chk("st_deliv", fetch_data, 32'hA0002001);
    chk("st_nostall", fetch_stall, 1'b0);

    // NOP injection on empty queue
    nop_mode = 1'b1; fetch_req = 1'b1; cyc();
    fetch_req = 1'b0; nop_mode = 1'b0;
    chk("nop_data", fetch_data, NOP);
    chk("nop_stall", fetch_stall, 1'b0);
    chk("nop_count", fetch_count, 16'd4);

    // Load with three wait states; wait_cycles change mid-access is ignored
    lq_push_valid = 1'b1; lq_push_data = 32'h13; cyc();
    lq_push_valid = 1'b0;
    wait_cycles = 4'd3; dc_req = 1'b1; dc_write = 1'b0; cyc();
    dc_req = 1'b0; wait_cycles = 4'd0;
    chk("ld3_stall1", dc_stall, 1'b1);
    chk("ld3_done1", dc_done, 1'b0);
    cyc(); chk("ld3_stall2", dc_stall, 1'b1);
    cyc(); chk("ld3_stall3", dc_stall, 1'b1);
    cyc();
    chk("ld3_done", dc_done, 1'b1);
    chk("ld3_stall4", dc_stall, 1'b0);
    chk("ld3_rdata", dc_rdata, 32'h13);
    cyc();
    chk("ld3_done_end", dc_done, 1'b0);
    chk("ld3_rdata_hold", dc_rdata, 32'h13);
    lq_push_valid = 1'b1; lq_push_data = 32'h55; cyc();
    lq_push_valid = 1'b0; dc_req = 1'b1; cyc();
    dc_req = 1'b0;
    chk("ld0_done", dc_done, 1'b1);
    chk("ld0_rdata", dc_rdata, 32'h55);
    cyc();

    // Store with two wait states, then load from an empty queue
    wait_cycles = 4'd2; dc_req = 1'b1; dc_write = 1'b1; dc_wdata = 32'hDEADBEEF; cyc();
    dc_req = 1'b0;
    chk("st2_stall1", dc_stall, 1'b1);
    cyc(); chk("st2_stall2", dc_stall, 1'b1);
    chk("st2_nopulse", st_valid, 1'b0);
    cyc();
    chk("st2_valid", st_valid, 1'b1);
    chk("st2_data", st_data, 32'hDEADBEEF);
    chk("st2_rdata_keep", dc_rdata, 32'h55);
    cyc();
    chk("st2_valid_end", st_valid, 1'b0);
    wait_cycles = 4'd0; dc_req = 1'b1; dc_write = 1'b0; cyc();
    dc_req = 1'b0;
    chk("uf_done", dc_done, 1'b1);
    chk("uf_rdata", dc_rdata, 32'h0);
    chk("uf_flag", ld_underflow, 1'b1);
    cyc();
    chk("uf_sticky", ld_underflow, 1'b1);

    // Fill the instruction queue, then reset in the middle of a wait
    iq_push_valid = 1'b1;
    for (int unsigned i = 0; i < IQD; i++) begin
      iq_push_data = 32'hC000_0000 + i;
      cyc();
    end
    chk("iq_full_ready", iq_push_ready, 1'b0);
    iq_push_data = 32'hBAD0_0000; fetch_req = 1'b1; cyc();
    fetch_req = 1'b0; iq_push_valid = 1'b0;
    chk("full_pop_data", fetch_data, 32'hC000_0000);
    chk("full_pop_ready", iq_push_ready, 1'b1);
    wait_cycles = 4'd5; dc_req = 1'b1; dc_write = 1'b1; dc_wdata = 32'h1234_5678; cyc();
    dc_req = 1'b0;
    cyc();
    chk("mid_stall", dc_stall, 1'b1);
    do_reset("rst1");
    for (int unsigned i = 0; i < 6; i++) begin
      cyc();
      chk("abort_done", dc_done, 1'b0);
      chk("abort_st", st_valid, 1'b0);
    end

    // Randomized traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      iq_push_valid = ($urandom_range(0, 99) < 45);
      iq_push_data  = $urandom;
      lq_push_valid = ($urandom_range(0, 99) < 35);
      lq_push_data  = $urandom;
      fetch_req     = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 99) < 5) nop_mode = 1'($urandom_range(0, 1));
      dc_req        = ($urandom_range(0, 99) < 40);
      dc_write      = 1'($urandom_range(0, 1));
      dc_wdata      = $urandom;
      wait_cycles   = WW'($urandom_range(0, 4));
      if ($urandom_range(0, 999) < 3) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/guvm_cache_responder.md
GUVM_CACHE_RESPONDER -- requirements
Module: guvm_cache_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning instruction/data word width.
REQ-002 SHALL have parameter IQ_DEPTH, default 8, meaning instruction queue depth (power of two, >=2).
REQ-003 SHALL have parameter LQ_DEPTH, default 4, meaning load-data queue depth (power of two, >=2).
REQ-004 SHALL have parameter WAIT_W, default 4, meaning width of wait-state count.
REQ-005 SHALL have parameter NOP_WORD, default 32'h01000000, meaning word injected on empty queue.
REQ-006 One clock; reset is asynchronous and active-high.
REQ-007 Ports:
 clk  in  1  clock, all logic on rising edge
 rst  in  1  asynchronous active-high reset
 iq_push_valid  in  1  bench offers instruction
 iq_push_data  in  DATA_W  instruction word
 iq_push_ready  out  1  instruction queue not full
 lq_push_valid  in  1  bench offers load data
 lq_push_data  in  DATA_W  load data word
 lq_push_ready  out  1  load queue not full
 nop_mode  in  1  0=stall on empty instruction queue, 1=inject NOP_WORD
 wait_cycles  in  WAIT_W  data-access wait states
 fetch_req  in  1  core fetch strobe
 fetch_data  out  DATA_W  instruction to core
 fetch_stall  out  1  instruction not yet available
 dc_req  in  1  core data access strobe
 dc_write  in  1  1=store, 0=load
 dc_wdata  in  DATA_W  store data
 dc_rdata  out  DATA_W  load data to core
 dc_stall  out  1  data access in progress
 dc_done  out  1  one-cycle completion pulse
 st_valid  out  1  one-cycle store-capture pulse
 st_data  out  DATA_W  captured store data
 ld_underflow  out  1  sticky: load completed with empty load queue
 fetch_count  out  16  instructions delivered, wraps at 2^16

Function
REQ-008 Queues SHALL be FIFOs; push accepted iff valid && ready; ready = not full; no bypass (word pushed in cycle N is poppable from N+1).
REQ-009 Full queue with simultaneous push and pop SHALL accept the pop only; push retried by bench.
REQ-010 Fetch: fetch_req sampled at cycle N with queue non-empty SHALL pop and drive fetch_data=head, fetch_stall=0 in cycle N+1.
REQ-011 Fetch with empty queue, nop_mode=1: SHALL drive fetch_data=NOP_WORD, fetch_stall=0 in N+1; no pop.
REQ-012 Fetch with empty queue, nop_mode=0: SHALL hold request pending with fetch_stall=1 from N+1 until the cycle after a word becomes available, then deliver it with fetch_stall=0.
REQ-013 New fetch_req while a request is pending SHALL be ignored; fetch_data SHALL hold its last value when no delivery occurs.
REQ-014 fetch_count SHALL increment on each delivery (including NOPs), wrapping 16'hFFFF->0.
REQ-015 Data FSM states IDLE, WAIT, RESP.
REQ-016 IDLE: dc_req SHALL latch dc_write, dc_wdata, load counter=wait_cycles; go WAIT if wait_cycles!=0 else RESP.
REQ-017 WAIT: dc_stall=1; counter decrements each cycle; at counter==1 go RESP.
REQ-018 RESP (one cycle): dc_stall=0, dc_done=1; load pops load queue and drives dc_rdata=head; store drives st_valid=1, st_data=latched wdata, dc_rdata unchanged; return IDLE.
REQ-019 Total data latency SHALL be wait_cycles+1 cycles from request cycle to dc_done.
REQ-020 dc_req outside IDLE SHALL be ignored; wait_cycles changes mid-access SHALL not affect the access.
REQ-021 Load in RESP with empty load queue SHALL drive dc_rdata=0 and set ld_underflow until reset.
REQ-022 Load-queue push and pop in the same cycle SHALL both take effect when not full.

Reset
REQ-023 rst SHALL immediately empty both queues, FSM->IDLE, fetch pending cleared, and drive: fetch_data=NOP_WORD, fetch_stall=0, dc_rdata=0, dc_stall=0, dc_done=0, st_valid=0, st_data=0, ld_underflow=0, fetch_count=0, iq_push_ready=1, lq_push_ready=1.
REQ-024 rst asserted mid-access SHALL abort it with no dc_done or st_valid pulse.

Verification
REQ-025 Push 8'h..: 0x8E00C002, 0x01000000; fetch_req two cycles -> fetch_data 0x8E00C002 then 0x01000000, stall 0, fetch_count=2.
REQ-026 nop_mode=0, empty queue, fetch_req; push 0xA0002001 three cycles later -> fetch_stall=1 until delivery, delivery one cycle after push.
REQ-027 nop_mode=1, empty queue, fetch_req -> fetch_data=0x01000000, stall 0, no pop.
REQ-028 wait_cycles=3, lq holds 0x13, load -> dc_stall 3 cycles, dc_done at request+4 with dc_rdata=0x13; wait_cycles=0 -> dc_done at request+1.
REQ-029 Store 0xDEADBEEF, wait_cycles=2 -> st_valid and st_data=0xDEADBEEF at request+3; load with empty lq -> dc_rdata=0, ld_underflow=1.
REQ-030 Fill IQ to 8 -> iq_push_ready=0; assert rst during WAIT -> all outputs at REQ-023 values, no dc_done.
